mem_read_arbiter: RTL and testbench
===================================

Name: mem_read_arbiter

Overview:
- Round-robin read arbiter between NUM_CONSUMERS instruction caches and one shared program-memory read port.
- Sits directly downstream of each cache's memory interface (mem_read_valid/address/ready/data) and upstream of the backing memory or memory controller.
- Has one outstanding memory transaction at a time.
- Returns each response only to the consumer that was granted.

Parameters:
- NUM_CONSUMERS, 4, number of requesting caches (1..16).
- ADDR_BITS, 8, read address width.
- DATA_BITS, 16, read data width.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; clears all state immediately on assertion.
- consumer_read_valid  input  NUM_CONSUMERS  per-consumer request; held high with a stable address until that consumer's ready pulses.
- consumer_read_address  input  NUM_CONSUMERS*ADDR_BITS  flattened addresses; lane i is bits [i*ADDR_BITS +: ADDR_BITS].
- consumer_read_ready  output  NUM_CONSUMERS  one-cycle response pulse for the granted lane.
- consumer_read_data  output  NUM_CONSUMERS*DATA_BITS  flattened data; a lane is updated only when its ready pulses, and otherwise holds its value.
- mem_read_valid  output  1  memory request.
- mem_read_address  output  ADDR_BITS  address latched from the granted consumer.
- mem_read_ready  input  1  memory response strobe.
- mem_read_data  input  DATA_BITS  memory data, valid while mem_read_ready is high.

Behaviour:
- Reset (reset low, asynchronous): state=IDLE, rr_ptr=0, grant_id=0.
  - All outputs are 0: mem_read_valid, mem_read_address, every consumer_read_ready bit, every consumer_read_data lane.
- All outputs are registered; no combinational path from input to output.
- IDLE:
  - If any consumer_read_valid bit is set, pick the first set bit at or after rr_ptr, searching circularly (wrap from NUM_CONSUMERS-1 to 0).
  - Latch grant_id and that lane's address into mem_read_address; set mem_read_valid=1; go to ISSUE.
  - If no bit is set, stay in IDLE.
- ISSUE:
  - mem_read_valid stays high and mem_read_address is stable.
  - When mem_read_ready=1 is sampled: clear mem_read_valid; write mem_read_data into lane grant_id; set consumer_read_ready[grant_id]=1; set rr_ptr=(grant_id+1) mod NUM_CONSUMERS; go to RESPOND.
  - No timeout; ISSUE waits indefinitely.
- RESPOND:
  - Exactly one cycle. Clear consumer_read_ready; go to IDLE.
  - This cycle lets the consumer drop its valid before the next arbitration.
- mem_read_ready is ignored outside ISSUE, including a stale high level left by a memory whose ready lags valid by a cycle.
- Latency with a 1-cycle registered memory:
  - Grant at edge t.
  - mem_read_ready sampled at t+2; consumer_read_ready high between t+2 and t+3.
  - Next grant no earlier than t+4, i.e. 4 cycles per transaction.
- At most one consumer_read_ready bit is high in any cycle.
- If the granted consumer drops valid early (protocol violation), the transaction still completes and ready still pulses.
- New or changed requests from other lanes during ISSUE/RESPOND are not sampled until IDLE.
- With a single requester continuously valid, it is re-granted every 4 cycles regardless of rr_ptr.
- Reset asserted mid-transaction aborts it: mem_read_valid drops immediately and no ready pulse is produced.
- NUM_CONSUMERS=1: arbitration degenerates to a pass-through with the same state sequence.

Decomposition:
- Package gpu_mem_pkg:
  - arb_state_t enum {IDLE, ISSUE, RESPOND}.
  - Localparam CONSUMER_ID_BITS = $clog2(NUM_CONSUMERS), minimum 1.
- Sub-module rr_picker: purely combinational.
  - Inputs: request vector, rr_ptr. Outputs: found, grant index.
  - Arbiter FSM, latches and the data demux stay in mem_read_arbiter.

Test Plan:
- Backing memory for all scenarios: data = 2*addr+1, 1-cycle registered response.
- Single request: consumer 2 reads address 0x05 → mem_read_address=0x05; consumer_read_ready[2] pulses for one cycle exactly 2 cycles after grant; lane 2 data = 0x000B; other lanes stay 0.
- Simultaneous requests: all 4 consumers valid from reset, addresses 0x10/0x11/0x12/0x13 → served in order 0,1,2,3 with data 0x21/0x23/0x25/0x27, one grant every 4 cycles.
- Fairness: consumers 0 and 3 held continuously valid → grants alternate 0,3,0,3; consumer 0 is never granted twice in a row.
- Wrap-around: after consumer 3 is served, consumers 1 and 2 request together → consumer 1 is granted first (rr_ptr wrapped to 0).
- Slow memory: mem_read_ready delayed 5 cycles, with a stale ready high during RESPOND → mem_read_valid and address held throughout ISSUE; exactly one ready pulse; the stale ready causes no extra grant.
- Reset mid-transaction: assert reset while in ISSUE → mem_read_valid is 0 before the next clock edge; after release, a pending request is re-granted from rr_ptr=0 and completes normally.

Source files
------------

// File: rtl/gpu_mem_pkg.sv
// Shared types and helpers for the program-memory read arbiter.
//   arb_state_t      : arbiter FSM states
//   consumer_id_bits : width of a consumer index, never less than 1
package gpu_mem_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RESPOND = 2'd2
    } arb_state_t;

    function automatic int unsigned consumer_id_bits(input int unsigned n);
        return (n > 32'd1) ? 32'($clog2(n)) : 32'd1;
    endfunction

    localparam int unsigned DEFAULT_NUM_CONSUMERS = 4;
    localparam int unsigned CONSUMER_ID_BITS      = consumer_id_bits(DEFAULT_NUM_CONSUMERS);

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request bit at or after rr_ptr,
// searching circularly.
//   request : per-consumer request vector
//   rr_ptr  : index where the search starts
//   found_c : some request bit is set
//   grant_c : index of the chosen request (0 when none)
module rr_picker
    import gpu_mem_pkg::*;
#(
    parameter int unsigned NUM_CONSUMERS = 4,
    parameter int unsigned ID_BITS       = consumer_id_bits(NUM_CONSUMERS)
) (
    input  logic [NUM_CONSUMERS-1:0] request,
    input  logic [ID_BITS-1:0]       rr_ptr,
    output logic                     found_c,
    output logic [ID_BITS-1:0]       grant_c
);

    logic [ID_BITS-1:0] idx_c;

    // Walk the lanes starting at rr_ptr; the first hit wins.
    always_comb begin
        found_c = 1'b0;
        grant_c = '0;
        idx_c   = '0;
        for (int unsigned i = 0; i < NUM_CONSUMERS; i++) begin
            idx_c = ID_BITS'((32'(rr_ptr) + i) % NUM_CONSUMERS);
            if (!found_c && request[idx_c]) begin
                found_c = 1'b1;
                grant_c = idx_c;
            end
        end
    end

endmodule

// File: rtl/mem_read_arbiter.sv
// Round-robin read arbiter between NUM_CONSUMERS caches and one shared
// program-memory read port, one outstanding transaction at a time.
//   clk, reset            : clock, asynchronous active-low reset
//   consumer_read_valid   : per-consumer request, held until its ready pulses
//   consumer_read_address : flattened lane addresses
//   consumer_read_ready   : one-cycle response pulse on the granted lane
//   consumer_read_data    : flattened lane data, updated only with ready
//   mem_read_valid/address: request to memory
//   mem_read_ready/data   : memory response
module mem_read_arbiter
    import gpu_mem_pkg::*;
#(
    parameter int unsigned NUM_CONSUMERS = 4,
    parameter int unsigned ADDR_BITS     = 8,
    parameter int unsigned DATA_BITS     = 16
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
    output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
    output logic                               mem_read_valid,
    output logic [ADDR_BITS-1:0]               mem_read_address,
    input  logic                               mem_read_ready,
    input  logic [DATA_BITS-1:0]               mem_read_data
);

    localparam int unsigned ID_BITS = consumer_id_bits(NUM_CONSUMERS);
    localparam logic [ID_BITS-1:0] LAST_ID = ID_BITS'(NUM_CONSUMERS - 1);

    arb_state_t         state;
    logic [ID_BITS-1:0] rr_ptr;
    logic [ID_BITS-1:0] grant_id;
    logic               found_c;
    logic [ID_BITS-1:0] pick_c;
    logic [ADDR_BITS-1:0] lane_addr [NUM_CONSUMERS];

    // Unflatten the address bus so the granted lane can be indexed directly.
    for (genvar g = 0; g < NUM_CONSUMERS; g++) begin : g_lane_addr
        assign lane_addr[g] = consumer_read_address[g*ADDR_BITS +: ADDR_BITS];
    end

    rr_picker #(
        .NUM_CONSUMERS(NUM_CONSUMERS),
        .ID_BITS      (ID_BITS)
    ) u_picker (
        .request(consumer_read_valid),
        .rr_ptr (rr_ptr),
        .found_c(found_c),
        .grant_c(pick_c)
    );

    // Arbiter FSM; mem_read_ready only matters while in ISSUE, so a lagging
    // ready level seen in RESPOND or IDLE is ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state               <= IDLE;
            rr_ptr              <= '0;
            grant_id            <= '0;
            mem_read_valid      <= 1'b0;
            mem_read_address    <= '0;
            consumer_read_ready <= '0;
            consumer_read_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found_c) begin
                        grant_id         <= pick_c;
                        mem_read_address <= lane_addr[pick_c];
                        mem_read_valid   <= 1'b1;
                        state            <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem_read_ready) begin
                        mem_read_valid <= 1'b0;
                        for (int unsigned i = 0; i < NUM_CONSUMERS; i++) begin
                            if (ID_BITS'(i) == grant_id) begin
                                consumer_read_data[i*DATA_BITS +: DATA_BITS] <= mem_read_data;
                                consumer_read_ready[i] <= 1'b1;
                            end
                        end
                        rr_ptr <= (grant_id == LAST_ID) ? '0 : grant_id + ID_BITS'(1);
                        state  <= RESPOND;
                    end
                end
                RESPOND: begin
                    consumer_read_ready <= '0;
                    state               <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Directed bench for mem_read_arbiter with a registered backing memory
// returning 2*addr+1 after a programmable delay.
module tb_mem_read_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned AW = 8;
    localparam int unsigned DW = 16;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [N-1:0]    consumer_read_valid;
    logic [N*AW-1:0] consumer_read_address;
    logic [N-1:0]    consumer_read_ready;
    logic [N*DW-1:0] consumer_read_data;
    logic            mem_read_valid;
    logic [AW-1:0]   mem_read_address;
    logic            mem_read_ready;
    logic [DW-1:0]   mem_read_data;

    int n_vec = 0;
    int n_err = 0;
    int onehot_err = 0;
    int cyc = 0;
    int mem_delay = 0;
    int mem_cnt = 0;

    mem_read_arbiter #(.NUM_CONSUMERS(N), .ADDR_BITS(AW), .DATA_BITS(DW)) dut (
        .clk                  (clk),
        .reset                (reset),
        .consumer_read_valid  (consumer_read_valid),
        .consumer_read_address(consumer_read_address),
        .consumer_read_ready  (consumer_read_ready),
        .consumer_read_data   (consumer_read_data),
        .mem_read_valid       (mem_read_valid),
        .mem_read_address     (mem_read_address),
        .mem_read_ready       (mem_read_ready),
        .mem_read_data        (mem_read_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Backing memory: answers mem_delay cycles after seeing valid, and keeps
    // answering while valid is still sampled high (stale ready).
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_read_ready <= 1'b0;
            mem_read_data  <= '0;
            mem_cnt        <= 0;
        end else if (mem_read_valid) begin
            if (mem_cnt >= mem_delay) begin
                mem_read_ready <= 1'b1;
                mem_read_data  <= DW'({mem_read_address, 1'b0}) + DW'(1);
            end else begin
                mem_read_ready <= 1'b0;
                mem_cnt        <= mem_cnt + 1;
            end
        end else begin
            mem_read_ready <= 1'b0;
            mem_cnt        <= 0;
        end
    end

    always @(negedge clk) begin
        if (reset && ($countones(consumer_read_ready) > 1)) onehot_err <= onehot_err + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [DW-1:0] lane_data(input int i);
        return consumer_read_data[i*DW +: DW];
    endfunction

    task automatic set_addr(input int i, input logic [AW-1:0] a);
        consumer_read_address[i*AW +: AW] = a;
    endtask

    // Waits (bounded) for a ready pulse; lane = -1 on timeout.
    task automatic wait_ready(input int budget, output int lane, output int at);
        bit done;
        lane = -1;
        at   = -1;
        done = 1'b0;
        for (int k = 0; k < budget && !done; k++) begin
            @(negedge clk);
            if (consumer_read_ready != '0) begin
                for (int j = 0; j < N; j++) if (consumer_read_ready[j]) lane = j;
                at   = cyc;
                done = 1'b1;
            end
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        @(negedge clk);
        n_vec++; if (mem_read_valid !== 1'b0) begin n_err++; $display("FAIL reset_mem_valid: got %0b expected 0", mem_read_valid); end
        n_vec++; if (mem_read_address !== 8'h00) begin n_err++; $display("FAIL reset_mem_addr: got %0h expected 0", mem_read_address); end
        n_vec++; if (consumer_read_ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready: got %0b expected 0000", consumer_read_ready); end
        n_vec++; if (consumer_read_data !== 64'h0) begin n_err++; $display("FAIL reset_data: got %0h expected 0", consumer_read_data); end
        reset = 1'b1;
    endtask

    task automatic test_single;
        set_addr(2, 8'h05);
        consumer_read_valid = 4'b0100;
        @(negedge clk);
        n_vec++; if (mem_read_valid !== 1'b1) begin n_err++; $display("FAIL single_grant_valid: got %0b expected 1", mem_read_valid); end
        n_vec++; if (mem_read_address !== 8'h05) begin n_err++; $display("FAIL single_grant_addr: got %0h expected 05", mem_read_address); end
        @(negedge clk);
        n_vec++; if (consumer_read_ready !== 4'b0000) begin n_err++; $display("FAIL single_early_ready: got %0b expected 0000", consumer_read_ready); end
        @(negedge clk);
        n_vec++; if (consumer_read_ready !== 4'b0100) begin n_err++; $display("FAIL single_ready: got %0b expected 0100", consumer_read_ready); end
        n_vec++; if (lane_data(2) !== 16'h000B) begin n_err++; $display("FAIL single_data: got %0h expected 000b", lane_data(2)); end
        n_vec++; if ({lane_data(3), lane_data(1), lane_data(0)} !== 48'h0) begin n_err++; $display("FAIL single_other_lanes: got %0h expected 0", {lane_data(3), lane_data(1), lane_data(0)}); end
        n_vec++; if (mem_read_valid !== 1'b0) begin n_err++; $display("FAIL single_valid_clear: got %0b expected 0", mem_read_valid); end
        consumer_read_valid = 4'b0000;
        @(negedge clk);
        n_vec++; if (consumer_read_ready !== 4'b0000) begin n_err++; $display("FAIL single_ready_width: got %0b expected 0000", consumer_read_ready); end
        @(negedge clk);
        n_vec++; if (mem_read_valid !== 1'b0) begin n_err++; $display("FAIL single_no_regrant: got %0b expected 0", mem_read_valid); end
    endtask

    task automatic test_simultaneous;
        int lane, at, prev;
        reset = 1'b0;
        for (int i = 0; i < N; i++) set_addr(i, 8'h10 + 8'(i));
        consumer_read_valid = 4'b1111;
        @(negedge clk);
        reset = 1'b1;
        prev = -1;
        for (int k = 0; k < N; k++) begin
            wait_ready(12, lane, at);
            n_vec++; if (lane !== k) begin n_err++; $display("FAIL simul_order[%0d]: got lane %0d expected %0d", k, lane, k); end
            if (lane >= 0) begin
                n_vec++; if (lane_data(k) !== 16'h0021 + 16'(2*k)) begin n_err++; $display("FAIL simul_data[%0d]: got %0h expected %0h", k, lane_data(k), 16'h0021 + 16'(2*k)); end
                consumer_read_valid[lane] = 1'b0;
            end
            if (prev >= 0) begin
                n_vec++; if (at - prev !== 4) begin n_err++; $display("FAIL simul_spacing[%0d]: got %0d expected 4", k, at - prev); end
            end
            prev = at;
        end
    endtask

    task automatic test_wraparound;
        int lane, at;
        set_addr(1, 8'h21);
        set_addr(2, 8'h22);
        consumer_read_valid = 4'b0110;
        wait_ready(12, lane, at);
        n_vec++; if (lane !== 1) begin n_err++; $display("FAIL wrap_first: got lane %0d expected 1", lane); end
        n_vec++; if (lane_data(1) !== 16'h0043) begin n_err++; $display("FAIL wrap_data1: got %0h expected 0043", lane_data(1)); end
        consumer_read_valid[1] = 1'b0;
        wait_ready(12, lane, at);
        n_vec++; if (lane !== 2) begin n_err++; $display("FAIL wrap_second: got lane %0d expected 2", lane); end
        n_vec++; if (lane_data(2) !== 16'h0045) begin n_err++; $display("FAIL wrap_data2: got %0h expected 0045", lane_data(2)); end
        consumer_read_valid = 4'b0000;
    endtask

    task automatic test_fairness;
        int lane, at, prev, exp_lane;
        reset = 1'b0;
        set_addr(0, 8'h30);
        set_addr(3, 8'h33);
        consumer_read_valid = 4'b1001;
        @(negedge clk);
        reset = 1'b1;
        prev = -1;
        for (int k = 0; k < 6; k++) begin
            exp_lane = (k % 2 == 0) ? 0 : 3;
            wait_ready(12, lane, at);
            n_vec++; if (lane !== exp_lane) begin n_err++; $display("FAIL fair_order[%0d]: got lane %0d expected %0d", k, lane, exp_lane); end
            if (prev >= 0) begin
                n_vec++; if (at - prev !== 4) begin n_err++; $display("FAIL fair_spacing[%0d]: got %0d expected 4", k, at - prev); end
            end
            prev = at;
        end
        n_vec++; if ({lane_data(3), lane_data(0)} !== 32'h0067_0061) begin n_err++; $display("FAIL fair_data: got %0h expected 00670061", {lane_data(3), lane_data(0)}); end
        consumer_read_valid = 4'b0000;
    endtask

    task automatic test_slow_memory;
        int held, extra;
        bit seen;
        mem_delay = 5;
        set_addr(2, 8'h40);
        consumer_read_valid = 4'b0100;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            if (mem_read_valid) seen = 1'b1;
        end
        n_vec++; if (seen !== 1'b1) begin n_err++; $display("FAIL slow_grant: got %0b expected 1", seen); end
        held = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (consumer_read_ready != '0) break;
            held++;
            n_vec++; if ({mem_read_valid, mem_read_address} !== 9'h140) begin n_err++; $display("FAIL slow_hold[%0d]: got %0h expected 140", k, {mem_read_valid, mem_read_address}); end
        end
        n_vec++; if (held !== 6) begin n_err++; $display("FAIL slow_issue_len: got %0d expected 6", held); end
        n_vec++; if (consumer_read_ready !== 4'b0100) begin n_err++; $display("FAIL slow_ready: got %0b expected 0100", consumer_read_ready); end
        n_vec++; if (lane_data(2) !== 16'h0081) begin n_err++; $display("FAIL slow_data: got %0h expected 0081", lane_data(2)); end
        consumer_read_valid = 4'b0000;
        extra = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (consumer_read_ready != '0 || mem_read_valid) extra++;
        end
        n_vec++; if (extra !== 0) begin n_err++; $display("FAIL slow_stale_ready: got %0d extra cycles expected 0", extra); end
        mem_delay = 0;
    endtask

    task automatic test_reset_mid;
        int lane, at;
        set_addr(1, 8'h50);
        set_addr(3, 8'h53);
        consumer_read_valid = 4'b1010;
        @(negedge clk);
        n_vec++; if ({mem_read_valid, mem_read_address} !== 9'h153) begin n_err++; $display("FAIL mid_grant: got %0h expected 153", {mem_read_valid, mem_read_address}); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_vec++; if (mem_read_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid_drop: got %0b expected 0", mem_read_valid); end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_vec++; if (consumer_read_ready !== 4'b0000) begin n_err++; $display("FAIL mid_no_pulse[%0d]: got %0b expected 0000", k, consumer_read_ready); end
        end
        reset = 1'b1;
        wait_ready(12, lane, at);
        n_vec++; if (lane !== 1) begin n_err++; $display("FAIL mid_regrant: got lane %0d expected 1", lane); end
        n_vec++; if ({lane_data(3), lane_data(1)} !== 32'h0000_00A1) begin n_err++; $display("FAIL mid_data1: got %0h expected 000000a1", {lane_data(3), lane_data(1)}); end
        consumer_read_valid[1] = 1'b0;
        wait_ready(12, lane, at);
        n_vec++; if (lane !== 3) begin n_err++; $display("FAIL mid_second: got lane %0d expected 3", lane); end
        n_vec++; if (lane_data(3) !== 16'h00A7) begin n_err++; $display("FAIL mid_data3: got %0h expected 00a7", lane_data(3)); end
        consumer_read_valid = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_onehot;
        n_vec++; if (onehot_err !== 0) begin n_err++; $display("FAIL onehot_ready: got %0d violations expected 0", onehot_err); end
    endtask

    initial begin
        consumer_read_valid   = '0;
        consumer_read_address = '0;
        reset = 1'b0;
        test_reset;
        test_single;
        test_simultaneous;
        test_wraparound;
        test_fairness;
        test_slow_memory;
        test_reset_mid;
        test_onehot;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
